// File: rtl/am_pkg.sv
// am_pkg: shared definitions for the alignment-marker receive path.
//   AM_BLOCK_W  - block width, 2-bit sync header included
//   SYNC_CTRL   - sync header carried by a marker block
//   am_state_e  - one-hot lock FSM state encoding
//   am_marker() - the 48 compared marker bits for a PCS lane
//   am_fields() - extracts the same 48 bits from a received block
// Marker bits are ordered {M6,M5,M4,M2,M1,M0}, matching block bits {[55:32],[23:0]}.
// M0 is in block[7:0]. BIP3 is in [31:24] and BIP7 is in [63:56]; both are never compared.
package am_pkg;

  localparam int         AM_BLOCK_W  = 66;
  localparam int         AM_LANE_MAX = 20;
  localparam logic [1:0] SYNC_CTRL   = 2'b10;

  typedef enum logic [4:0] {
    ST_INVALID   = 5'b00001,
    ST_SYNC      = 5'b00010,
    ST_FIRST     = 5'b00100,
    ST_LOCK      = 5'b01000,
    ST_SLIP_WAIT = 5'b10000
  } am_state_e;

  function automatic logic [47:0] am_marker(input int lane);
    logic [47:0] m;
    case (lane)
      0:       m = {8'hDE, 8'h97, 8'h3E, 8'h21, 8'h68, 8'hC1};
      1:       m = {8'h71, 8'h8E, 8'h62, 8'h8E, 8'h71, 8'h9D};
      2:       m = {8'h17, 8'hB4, 8'hA6, 8'hE8, 8'h4B, 8'h59};
      3:       m = {8'h84, 8'h6A, 8'hB2, 8'h7B, 8'h95, 8'h4D};
      4:       m = {8'hF6, 8'hF8, 8'h0A, 8'h09, 8'h07, 8'hF5};
      5:       m = {8'h3D, 8'hEB, 8'h22, 8'hC2, 8'h14, 8'hDD};
      6:       m = {8'hD9, 8'hB5, 8'h65, 8'h26, 8'h4A, 8'h9A};
      7:       m = {8'h99, 8'hBA, 8'h84, 8'h66, 8'h45, 8'h7B};
      8:       m = {8'h89, 8'hDB, 8'h5F, 8'h76, 8'h24, 8'hA0};
      9:       m = {8'h04, 8'h36, 8'h97, 8'hFB, 8'hC9, 8'h68};
      10:      m = {8'h66, 8'h93, 8'h02, 8'h99, 8'h6C, 8'hFD};
      11:      m = {8'hAA, 8'h6E, 8'h46, 8'h55, 8'h91, 8'hB9};
      12:      m = {8'h4D, 8'h46, 8'hA3, 8'hB2, 8'hB9, 8'h5C};
      13:      m = {8'h42, 8'h07, 8'hE5, 8'hBD, 8'hF8, 8'h1A};
      14:      m = {8'h35, 8'h38, 8'h7C, 8'hCA, 8'hC7, 8'h83};
      15:      m = {8'h32, 8'hC9, 8'hCA, 8'hCD, 8'h36, 8'h35};
      16:      m = {8'hB3, 8'hCE, 8'h3B, 8'h4C, 8'h31, 8'hC4};
      17:      m = {8'h48, 8'h29, 8'h52, 8'hB7, 8'hD6, 8'hAD};
      18:      m = {8'hD5, 8'h99, 8'hA0, 8'h2A, 8'h66, 8'h5F};
      19:      m = {8'h1A, 8'h0F, 8'h3F, 8'hE5, 8'hF0, 8'hC0};
      default: m = '0;
    endcase
    return m;
  endfunction

  function automatic logic [47:0] am_fields(input logic [AM_BLOCK_W-1:0] blk);
    return {blk[55:32], blk[23:0]};
  endfunction

endpackage

// File: rtl/am_match.sv
// am_match: combinational alignment-marker lane identification.
//   block_i      - received block, sync header in the top two bits
//   hit_onehot_o - one bit per lane whose marker matches block_i
//   hit_id_o     - binary index of the matching lane (0 when there is no match)
//   hit_any_o    - some lane matched
// The marker codes are pairwise distinct, so at most one bit of hit_onehot_o is set.
// Because of that, OR-ing the indices of the hits gives the binary ID.
module am_match
  import am_pkg::*;
#(
  parameter int LANE_N  = 4,
  parameter int LANE_W  = (LANE_N > 1) ? $clog2(LANE_N) : 1,
  parameter int BLOCK_W = AM_BLOCK_W
) (
  input  logic [BLOCK_W-1:0] block_i,
  output logic [LANE_N-1:0]  hit_onehot_o,
  output logic [LANE_W-1:0]  hit_id_o,
  output logic               hit_any_o
);

  logic        hdr_ok;
  logic [47:0] fields;
  logic        unused_bip;

  assign hdr_ok     = (block_i[65:64] == SYNC_CTRL);
  assign fields     = am_fields(block_i[65:0]);
  assign unused_bip = ^{block_i[63:56], block_i[31:24]};

  always_comb begin
    hit_onehot_o = '0;
    hit_id_o     = '0;
    for (int l = 0; l < LANE_N; l++) begin
      if (hdr_ok && (fields == am_marker(l))) begin
        hit_onehot_o[l] = 1'b1;
        hit_id_o        = hit_id_o | LANE_W'(l);
      end
    end
  end

  assign hit_any_o = |hit_onehot_o;

endmodule

// File: rtl/am_lock_rx_multi.sv
// am_lock_rx_multi: per-lane alignment-marker lock FSM for multi-lane PCS receive.
//   clk, reset  - PCS rx clock, async active-high reset
//   signal_ok_i - lane block lock; when low, the FSM returns to INVALID
//   valid_i     - block_i qualifier; cycles with valid_i low freeze state and counters
//   block_i     - received 66-bit block
//   slip_v_o    - one-cycle slip request to the gearbox
//   lock_v_o    - marker lock achieved
//   lane_o      - binary ID of the PCS lane carried
//   am_v_o      - block_i is the expected, matching marker
//   am_err_o    - the expected marker position in LOCK did not match lane_o
//
// state      | meaning
// INVALID    | no block lock; outputs idle
// SYNC       | search: every valid block is tested against all lanes
// FIRST      | one marker seen; confirming at period boundaries
// LOCK       | locked; counting consecutive bad markers
// SLIP_WAIT  | slip issued; ignore SLIP_WAIT_N valid blocks while the gearbox shifts
module am_lock_rx_multi
  import am_pkg::*;
#(
  parameter int BLOCK_W     = AM_BLOCK_W,
  parameter int LANE_N      = 4,
  parameter int LANE_W      = (LANE_N > 1) ? $clog2(LANE_N) : 1,
  parameter int AM_PERIOD   = 16384,
  parameter int VLD_CNT_N   = 2,
  parameter int NV_CNT_N    = 4,
  parameter int SLIP_WAIT_N = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               signal_ok_i,
  input  logic               valid_i,
  input  logic [BLOCK_W-1:0] block_i,
  output logic               slip_v_o,
  output logic               lock_v_o,
  output logic [LANE_W-1:0]  lane_o,
  output logic               am_v_o,
  output logic               am_err_o
);

  localparam int GAP_W  = $clog2(AM_PERIOD);
  localparam int GOOD_W = $clog2(VLD_CNT_N + 1);
  localparam int NV_W   = $clog2(NV_CNT_N + 1);
  localparam int WCNT_W = $clog2(SLIP_WAIT_N + 1);

  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(AM_PERIOD - 1);
  localparam logic [GOOD_W-1:0] GOOD_DONE = GOOD_W'(VLD_CNT_N);
  localparam logic [NV_W-1:0]   NV_DONE   = NV_W'(NV_CNT_N);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(SLIP_WAIT_N - 1);

  am_state_e          state_q, state_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [GOOD_W-1:0]  good_q, good_d;
  logic [NV_W-1:0]    nv_q, nv_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic [LANE_W-1:0]  lane_q, lane_d;
  logic               lock_q, lock_d;

  logic [LANE_N-1:0]  hit_onehot;
  logic [LANE_W-1:0]  hit_id;
  logic               hit_any;
  logic [LANE_N-1:0]  lane_mask;
  logic               same_lane;
  logic               at_marker;
  logic [GAP_W-1:0]   gap_inc;
  logic [GOOD_W-1:0]  good_inc;
  logic [NV_W-1:0]    nv_inc;
  logic               slip_v, am_v, am_err, drop;

  am_match #(
    .LANE_N  (LANE_N),
    .LANE_W  (LANE_W),
    .BLOCK_W (BLOCK_W)
  ) u_match (
    .block_i      (block_i),
    .hit_onehot_o (hit_onehot),
    .hit_id_o     (hit_id),
    .hit_any_o    (hit_any)
  );

  assign lane_mask = LANE_N'(1) << lane_q;
  assign same_lane = |(hit_onehot & lane_mask);
  assign at_marker = (gap_q == '0);
  assign gap_inc   = (gap_q == GAP_LAST) ? '0 : gap_q + GAP_W'(1);
  assign good_inc  = good_q + GOOD_W'(1);
  assign nv_inc    = nv_q + NV_W'(1);

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    good_d  = good_q;
    nv_d    = nv_q;
    wcnt_d  = wcnt_q;
    lane_d  = lane_q;
    lock_d  = lock_q;
    slip_v  = 1'b0;
    am_v    = 1'b0;
    am_err  = 1'b0;
    drop    = 1'b0;

    // Loss of block lock takes priority over everything, including a pending slip.
    if (!signal_ok_i) begin
      state_d = ST_INVALID;
      gap_d   = '0;
      good_d  = '0;
      nv_d    = '0;
      wcnt_d  = '0;
      lane_d  = '0;
      lock_d  = 1'b0;
    end else begin
      case (state_q)
        ST_INVALID: state_d = ST_SYNC;

        ST_SYNC: if (valid_i) begin
          if (hit_any) begin
            state_d = ST_FIRST;
            lane_d  = hit_id;
            gap_d   = GAP_W'(1);
            good_d  = GOOD_W'(1);
            nv_d    = '0;
            am_v    = 1'b1;
          end else begin
            slip_v  = 1'b1;
            state_d = ST_SLIP_WAIT;
            wcnt_d  = '0;
          end
        end

        ST_FIRST: if (valid_i) begin
          gap_d = gap_inc;
          if (at_marker) begin
            if (same_lane) begin
              am_v   = 1'b1;
              good_d = good_inc;
              if (good_inc == GOOD_DONE) begin
                state_d = ST_LOCK;
                lock_d  = 1'b1;
                nv_d    = '0;
              end
            end else begin
              slip_v  = 1'b1;
              state_d = ST_SLIP_WAIT;
              wcnt_d  = '0;
              good_d  = '0;
            end
          end
        end

        ST_LOCK: if (valid_i) begin
          gap_d = gap_inc;
          if (at_marker) begin
            if (same_lane) begin
              am_v = 1'b1;
              nv_d = '0;
            end else begin
              am_err = 1'b1;
              nv_d   = nv_inc;
              if (nv_inc == NV_DONE) begin
                slip_v  = 1'b1;
                drop    = 1'b1;
                lock_d  = 1'b0;
                state_d = ST_SLIP_WAIT;
                wcnt_d  = '0;
                nv_d    = '0;
                good_d  = '0;
              end
            end
          end
        end

        ST_SLIP_WAIT: if (valid_i) begin
          if (wcnt_q == WCNT_LAST) begin
            state_d = ST_SYNC;
            wcnt_d  = '0;
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end

        default: state_d = ST_INVALID;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_INVALID;
      gap_q   <= '0;
      good_q  <= '0;
      nv_q    <= '0;
      wcnt_q  <= '0;
      lane_q  <= '0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      good_q  <= good_d;
      nv_q    <= nv_d;
      wcnt_q  <= wcnt_d;
      lane_q  <= lane_d;
      lock_q  <= lock_d;
    end
  end

  // Lock rises one cycle after the locking marker, but it falls in the same
  // cycle as the unlocking slip.
  assign slip_v_o = slip_v;
  assign am_v_o   = am_v;
  assign am_err_o = am_err;
  assign lock_v_o = lock_q & ~drop;
  assign lane_o   = lane_q;

endmodule

// File: tb/tb_am_lock_rx_multi.sv
module tb_am_lock_rx_multi;

  localparam int K_DATA = -1;
  localparam int K_BAD  = -2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        signal_ok_i = 1'b0;
  logic        valid_i = 1'b0;
  logic [65:0] block_i = '0;
  logic        slip_v_o, lock_v_o, am_v_o, am_err_o;
  logic [1:0]  lane_o;

  int passed = 0;
  int total  = 0;
  int salt   = 0;

  typedef struct {
    int n;
    bit v;
    bit sok;
    int kind;
    bit slip;
    bit am;
    bit err;
    bit lock;
    int lane;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  am_lock_rx_multi #(
    .BLOCK_W(66), .LANE_N(4), .AM_PERIOD(16), .VLD_CNT_N(2), .NV_CNT_N(4), .SLIP_WAIT_N(4)
  ) dut (
    .clk(clk), .reset(reset), .signal_ok_i(signal_ok_i), .valid_i(valid_i), .block_i(block_i),
    .slip_v_o(slip_v_o), .lock_v_o(lock_v_o), .lane_o(lane_o), .am_v_o(am_v_o), .am_err_o(am_err_o)
  );

  // Marker bytes {M0,M1,M2,M4,M5,M6} for PCS lanes 0..3.
  function automatic logic [47:0] ref_bytes(int lane);
    case (lane)
      0:       return 48'hC1_68_21_3E_97_DE;
      1:       return 48'h9D_71_8E_62_8E_71;
      2:       return 48'h59_4B_E8_A6_B4_17;
      default: return 48'h4D_95_7B_B2_6A_84;
    endcase
  endfunction

  function automatic logic [65:0] mk_block(int kind, int s);
    logic [47:0] b;
    logic [7:0]  bip;
    bip = 8'(s * 37);
    if (kind == K_DATA)
      return {2'b01, 64'hA5C3_0F00_0000_0000 | 64'(s)};
    b = ref_bytes((kind == K_BAD) ? 1 : kind);
    if (kind == K_BAD) b[15:8] = b[15:8] ^ 8'h01;
    // {hdr, BIP7, M6, M5, M4, BIP3, M2, M1, M0}
    return {2'b10, ~bip, b[7:0], b[15:8], b[23:16], bip, b[31:24], b[39:32], b[47:40]};
  endfunction

  function automatic void add(int n, bit v, bit sok, int kind,
                              bit slip, bit am, bit err, bit lock, int lane);
    vq.push_back('{n, v, sok, kind, slip, am, err, lock, lane});
  endfunction

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic chk_all(string tag, bit slip, bit am, bit err, bit lock, int lane);
    chk({tag, " slip"}, int'(slip_v_o), int'(slip));
    chk({tag, " am_v"}, int'(am_v_o), int'(am));
    chk({tag, " am_err"}, int'(am_err_o), int'(err));
    chk({tag, " lock"}, int'(lock_v_o), int'(lock));
    chk({tag, " lane"}, int'(lane_o), lane);
  endtask

  task automatic run_vectors(string grp);
    foreach (vq[i]) begin
      for (int k = 0; k < vq[i].n; k++) begin
        @(negedge clk);
        signal_ok_i = vq[i].sok;
        valid_i     = vq[i].v;
        block_i     = mk_block(vq[i].kind, salt);
        salt++;
        #2;
        chk_all($sformatf("%s v%0d.%0d", grp, i, k),
                vq[i].slip, vq[i].am, vq[i].err, vq[i].lock, vq[i].lane);
      end
    end
    vq.delete();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #2;
    chk_all("in_reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    // INVALID -> SYNC
    add(1, 0, 1, K_DATA, 0, 0, 0, 0, 0);
    // lane 2 markers at valid blocks 0 and 16; lock the cycle after block 16
    add(1, 1, 1, 2,      0, 1, 0, 0, 0);
    add(15, 1, 1, K_DATA, 0, 0, 0, 0, 2);
    add(1, 1, 1, 2,      0, 1, 0, 0, 2);
    add(1, 1, 1, K_DATA, 0, 0, 0, 1, 2);
    // 5 bubbles mid-period (marker on the bus, must be ignored)
    add(6, 1, 1, K_DATA, 0, 0, 0, 1, 2);
    add(5, 0, 1, 2,      0, 0, 0, 1, 2);
    add(8, 1, 1, K_DATA, 0, 0, 0, 1, 2);
    add(1, 1, 1, 2,      0, 1, 0, 1, 2);
    // signal_ok drop in LOCK
    add(1, 1, 0, K_DATA, 0, 0, 0, 1, 2);
    add(1, 0, 1, K_DATA, 0, 0, 0, 0, 0);
    // no-match stream: slip, 4 quiet blocks, slip again
    add(1, 1, 1, K_DATA, 1, 0, 0, 0, 0);
    add(4, 1, 1, K_DATA, 0, 0, 0, 0, 0);
    add(1, 1, 1, K_DATA, 1, 0, 0, 0, 0);
    add(4, 1, 1, K_DATA, 0, 0, 0, 0, 0);
    // lane 0 in FIRST, then lane 3 at the marker position
    add(1, 1, 1, 0,      0, 1, 0, 0, 0);
    add(15, 1, 1, K_DATA, 0, 0, 0, 0, 0);
    add(1, 1, 1, 3,      1, 0, 0, 0, 0);
    add(4, 1, 1, K_DATA, 0, 0, 0, 0, 0);
    // signal_ok low where a SYNC slip would fire
    add(1, 1, 0, K_DATA, 0, 0, 0, 0, 0);
    add(1, 0, 1, K_DATA, 0, 0, 0, 0, 0);
    // lock lane 1, 3 bad, 1 good, 4 bad
    add(1, 1, 1, 1,      0, 1, 0, 0, 0);
    add(15, 1, 1, K_DATA, 0, 0, 0, 0, 1);
    add(1, 1, 1, 1,      0, 1, 0, 0, 1);
    add(15, 1, 1, K_DATA, 0, 0, 0, 1, 1);
    add(1, 1, 1, K_BAD,  0, 0, 1, 1, 1);
    add(15, 1, 1, K_DATA, 0, 0, 0, 1, 1);
    add(1, 1, 1, 3,      0, 0, 1, 1, 1);
    add(15, 1, 1, K_DATA, 0, 0, 0, 1, 1);
    add(1, 1, 1, K_DATA, 0, 0, 1, 1, 1);
    add(15, 1, 1, K_DATA, 0, 0, 0, 1, 1);
    add(1, 1, 1, 1,      0, 1, 0, 1, 1);
    add(15, 1, 1, K_DATA, 0, 0, 0, 1, 1);
    add(1, 1, 1, K_BAD,  0, 0, 1, 1, 1);
    add(15, 1, 1, K_DATA, 0, 0, 0, 1, 1);
    add(1, 1, 1, K_BAD,  0, 0, 1, 1, 1);
    add(15, 1, 1, K_DATA, 0, 0, 0, 1, 1);
    add(1, 1, 1, K_BAD,  0, 0, 1, 1, 1);
    add(15, 1, 1, K_DATA, 0, 0, 0, 1, 1);
    add(1, 1, 1, K_BAD,  1, 0, 1, 0, 1);
    add(4, 1, 1, K_DATA, 0, 0, 0, 0, 1);
    // relock on lane 3
    add(1, 1, 1, 3,      0, 1, 0, 0, 1);
    add(15, 1, 1, K_DATA, 0, 0, 0, 0, 3);
    add(1, 1, 1, 3,      0, 1, 0, 0, 3);
    add(1, 1, 1, K_DATA, 0, 0, 0, 1, 3);
    run_vectors("p1");

    // async reset pulse while locked
    @(negedge clk);
    valid_i = 1'b1;
    block_i = mk_block(3, salt);
    #1;
    chk("pre_reset lock", int'(lock_v_o), 1);
    reset = 1'b1;
    #1;
    chk_all("async_reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    // relock after reset needs two markers
    add(1, 0, 1, K_DATA, 0, 0, 0, 0, 0);
    add(1, 1, 1, 3,      0, 1, 0, 0, 0);
    add(15, 1, 1, K_DATA, 0, 0, 0, 0, 3);
    add(1, 1, 1, 3,      0, 1, 0, 0, 3);
    add(1, 1, 1, K_DATA, 0, 0, 0, 1, 3);
    run_vectors("p2");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
